// File: rtl/bacdctx_if.sv
// bacdctx_if: bundle of the slink word input and the MAC tx byte output.
//   master : the environment. Drives mm words and the MAC FIFO almost-full.
//   slave  : bacdctx. Returns rdy and drives the byte stream.
// Signals:
//   mm_slink_dval/data[17:0]/odd  word in ([17] sop, [16] eop, [15:8] hi, [7:0] lo)
//   slink_mm_rdy                  word accepted when dval && rdy
//   mactx_txfifo_afull            stall byte output
//   mactx_txfifo_dval/sop/eop/data registered byte stream
interface bacdctx_if;
  logic        mm_slink_dval;
  logic [17:0] mm_slink_data;
  logic        mm_slink_odd;
  logic        slink_mm_rdy;
  logic        mactx_txfifo_afull;
  logic        mactx_txfifo_dval;
  logic        mactx_txfifo_sop;
  logic        mactx_txfifo_eop;
  logic [7:0]  mactx_txfifo_data;

  modport master (
    output mm_slink_dval, mm_slink_data, mm_slink_odd, mactx_txfifo_afull,
    input  slink_mm_rdy, mactx_txfifo_dval, mactx_txfifo_sop,
           mactx_txfifo_eop, mactx_txfifo_data
  );

  modport slave (
    input  mm_slink_dval, mm_slink_data, mm_slink_odd, mactx_txfifo_afull,
    output slink_mm_rdy, mactx_txfifo_dval, mactx_txfifo_sop,
           mactx_txfifo_eop, mactx_txfifo_data
  );
endinterface

// File: rtl/bacdctx.sv
// bacdctx: slink transmit byte-width converter.
// Takes 18-bit framed words (2 bytes + sop/eop + odd marker) and serialises
// them high byte first onto the 8-bit MAC tx stream. Truncates frames at
// MAX_LEN bytes, inserts IFG_CYCLES idle cycles after each eop byte and
// stalls on the MAC tx FIFO almost-full.
// Ports:
//   clk        clock
//   rst        synchronous reset, active-high
//   bus        bacdctx_if.slave (mm word input, MAC byte output)
//   slink_err  one-cycle error pulse (word without sop in IDLE, sop inside a
//              frame, max-length truncation)
// Optional: define BACDCTX_PAD_EN to pad short frames with 0x00 up to MIN_LEN.
//
// state | meaning
// IDLE  | waiting for a sop word
// HI    | emitting hold[15:8]
// LO    | emitting hold[7:0], may accept the next word in the same cycle
// WAIT  | mid-frame, waiting for the next word
// DROP  | frame truncated, swallowing words up to the eop word
// GAP   | inter-frame gap countdown
// PAD   | emitting 0x00 fill bytes (BACDCTX_PAD_EN only)
module bacdctx #(
  parameter int unsigned MAX_LEN    = 1518,
  parameter int unsigned IFG_CYCLES = 12
`ifdef BACDCTX_PAD_EN
  ,
  parameter int unsigned MIN_LEN    = 64
`endif
) (
  input  logic     clk,
  input  logic     rst,
  bacdctx_if.slave bus,
  output logic     slink_err
);

  localparam logic [11:0] MAX_LEN_C = 12'(MAX_LEN);
  localparam logic [7:0]  IFG_C     = 8'(IFG_CYCLES);
`ifdef BACDCTX_PAD_EN
  localparam logic [11:0] MIN_LEN_C = 12'(MIN_LEN);
`endif

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HI   = 3'd1,
    ST_LO   = 3'd2,
    ST_WAIT = 3'd3,
    ST_DROP = 3'd4,
    ST_GAP  = 3'd5
`ifdef BACDCTX_PAD_EN
    ,
    ST_PAD  = 3'd6
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] hold_data_q, hold_data_d;
  logic        hold_eop_q, hold_eop_d;
  logic        hold_odd_q, hold_odd_d;
  logic        first_q, first_d;
  logic [11:0] cnt_q, cnt_d;
  logic [7:0]  gap_q, gap_d;
  logic        run_q, run_d;
  logic        dval_q, dval_d;
  logic        sop_q, sop_d;
  logic        eop_q, eop_d;
  logic [7:0]  data_q, data_d;
  logic        err_q, err_d;

  logic        rdy;
  logic        accept;
  logic        in_sop;
  logic        in_eop;
  logic        load;
  logic        emit;
  logic        emit_last;
  logic [7:0]  emit_byte;
  logic [11:0] cnt_inc;

  assign in_sop = bus.mm_slink_data[17];
  assign in_eop = bus.mm_slink_data[16];
  assign accept = bus.mm_slink_dval && rdy;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_data_q <= '0;
      hold_eop_q  <= 1'b0;
      hold_odd_q  <= 1'b0;
      first_q     <= 1'b0;
      cnt_q       <= '0;
      gap_q       <= '0;
      run_q       <= 1'b0;
      dval_q      <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      data_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_eop_q  <= hold_eop_d;
      hold_odd_q  <= hold_odd_d;
      first_q     <= first_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      run_q       <= run_d;
      dval_q      <= dval_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      data_q      <= data_d;
      err_q       <= err_d;
    end
  end

  // Next-state and byte decision
  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_eop_d  = hold_eop_q;
    hold_odd_d  = hold_odd_q;
    first_d     = first_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    run_d       = 1'b1;
    dval_d      = 1'b0;
    sop_d       = 1'b0;
    eop_d       = 1'b0;
    data_d      = '0;
    err_d       = 1'b0;
    load        = 1'b0;
    emit        = 1'b0;
    emit_last   = 1'b0;
    emit_byte   = '0;
    cnt_inc     = cnt_q + 12'd1;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (in_sop) begin
            load    = 1'b1;
            first_d = 1'b1;
            cnt_d   = '0;
            state_d = ST_HI;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_HI: begin
        if (!bus.mactx_txfifo_afull) begin
          emit      = 1'b1;
          emit_byte = hold_data_q[15:8];
          emit_last = hold_eop_q && hold_odd_q;
        end
      end
      ST_LO: begin
        if (!bus.mactx_txfifo_afull) begin
          emit      = 1'b1;
          emit_byte = hold_data_q[7:0];
          emit_last = hold_eop_q;
        end
      end
      ST_WAIT: begin
        if (accept) begin
          load    = 1'b1;
          err_d   = in_sop;
          state_d = ST_HI;
        end
      end
      ST_DROP: begin
        if (accept && in_eop) begin
          state_d = ST_GAP;
          gap_d   = IFG_C;
        end
      end
      ST_GAP: begin
        // The cycle still showing the eop byte does not count as idle.
        if (!dval_q) begin
          if (gap_q <= 8'd1) begin
            state_d = ST_IDLE;
          end else begin
            gap_d = gap_q - 8'd1;
          end
        end
      end
`ifdef BACDCTX_PAD_EN
      ST_PAD: begin
        if (!bus.mactx_txfifo_afull) begin
          emit      = 1'b1;
          emit_byte = 8'h00;
          emit_last = (cnt_inc == MIN_LEN_C);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    if (emit) begin
      dval_d  = 1'b1;
      sop_d   = first_q;
      data_d  = emit_byte;
      first_d = 1'b0;
      cnt_d   = cnt_inc;
      if (emit_last) begin
`ifdef BACDCTX_PAD_EN
        if (cnt_inc < MIN_LEN_C) begin
          state_d = ST_PAD;
        end else
`endif
        begin
          eop_d   = 1'b1;
          state_d = ST_GAP;
          gap_d   = IFG_C;
        end
      end else if (cnt_inc == MAX_LEN_C) begin
        // Truncate: a word taken in this same LO cycle is discarded, but its
        // eop still ends the frame.
        eop_d   = 1'b1;
        err_d   = 1'b1;
        gap_d   = IFG_C;
        state_d = (hold_eop_q || (accept && in_eop)) ? ST_GAP : ST_DROP;
      end else if (state_q == ST_HI) begin
        state_d = ST_LO;
`ifdef BACDCTX_PAD_EN
      end else if (state_q == ST_PAD) begin
        state_d = ST_PAD;
`endif
      end else if (accept) begin
        load    = 1'b1;
        err_d   = in_sop;
        state_d = ST_HI;
      end else begin
        state_d = ST_WAIT;
      end
    end

    if (load) begin
      hold_data_d = bus.mm_slink_data[15:0];
      hold_eop_d  = in_eop;
      hold_odd_d  = bus.mm_slink_odd;
    end
  end

  // Outputs
  always_comb begin
    rdy = 1'b0;
    if (run_q) begin
      case (state_q)
        ST_IDLE, ST_WAIT, ST_DROP: rdy = 1'b1;
        ST_LO:                     rdy = !bus.mactx_txfifo_afull && !hold_eop_q;
        default:                   rdy = 1'b0;
      endcase
    end
  end

  assign bus.slink_mm_rdy      = rdy;
  assign bus.mactx_txfifo_dval = dval_q;
  assign bus.mactx_txfifo_sop  = sop_q;
  assign bus.mactx_txfifo_eop  = eop_q;
  assign bus.mactx_txfifo_data = data_q;
  assign slink_err             = err_q;

endmodule

// File: tb/tb_bacdctx.sv
module tb_bacdctx;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          sel = 0;
  logic        drv_dval = 1'b0;
  logic [17:0] drv_data = '0;
  logic        drv_odd = 1'b0;
  logic        drv_afull = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int err_cnt = 0;

  logic [7:0] q_data[$];
  logic       q_sop[$];
  logic       q_eop[$];
  int         q_cyc[$];

  logic       err0, err1, err2;
  logic       mon_dval, mon_sop, mon_eop, mon_rdy, mon_err;
  logic [7:0] mon_data;

  always #5 clk = ~clk;

  bacdctx_if bus0();
  bacdctx_if bus1();
  bacdctx_if bus2();

  assign bus0.mm_slink_dval      = drv_dval && (sel == 0);
  assign bus0.mm_slink_data      = drv_data;
  assign bus0.mm_slink_odd       = drv_odd;
  assign bus0.mactx_txfifo_afull = drv_afull;
  assign bus1.mm_slink_dval      = drv_dval && (sel == 1);
  assign bus1.mm_slink_data      = drv_data;
  assign bus1.mm_slink_odd       = drv_odd;
  assign bus1.mactx_txfifo_afull = drv_afull;
  assign bus2.mm_slink_dval      = drv_dval && (sel == 2);
  assign bus2.mm_slink_data      = drv_data;
  assign bus2.mm_slink_odd       = drv_odd;
  assign bus2.mactx_txfifo_afull = drv_afull;

  bacdctx #(.MAX_LEN(1518), .IFG_CYCLES(12)
`ifdef BACDCTX_PAD_EN
    , .MIN_LEN(2)
`endif
  ) u_dut (.clk(clk), .rst(rst), .bus(bus0), .slink_err(err0));

  bacdctx #(.MAX_LEN(6), .IFG_CYCLES(12)
`ifdef BACDCTX_PAD_EN
    , .MIN_LEN(2)
`endif
  ) u_dut_ml (.clk(clk), .rst(rst), .bus(bus1), .slink_err(err1));

`ifdef BACDCTX_PAD_EN
  bacdctx #(.MAX_LEN(1518), .IFG_CYCLES(12), .MIN_LEN(8))
    u_dut_pad (.clk(clk), .rst(rst), .bus(bus2), .slink_err(err2));
`else
  assign bus2.slink_mm_rdy      = 1'b0;
  assign bus2.mactx_txfifo_dval = 1'b0;
  assign bus2.mactx_txfifo_sop  = 1'b0;
  assign bus2.mactx_txfifo_eop  = 1'b0;
  assign bus2.mactx_txfifo_data = 8'h00;
  assign err2                   = 1'b0;
`endif

  always_comb begin
    mon_dval = bus0.mactx_txfifo_dval;
    mon_sop  = bus0.mactx_txfifo_sop;
    mon_eop  = bus0.mactx_txfifo_eop;
    mon_data = bus0.mactx_txfifo_data;
    mon_rdy  = bus0.slink_mm_rdy;
    mon_err  = err0;
    if (sel == 1) begin
      mon_dval = bus1.mactx_txfifo_dval;
      mon_sop  = bus1.mactx_txfifo_sop;
      mon_eop  = bus1.mactx_txfifo_eop;
      mon_data = bus1.mactx_txfifo_data;
      mon_rdy  = bus1.slink_mm_rdy;
      mon_err  = err1;
    end else if (sel == 2) begin
      mon_dval = bus2.mactx_txfifo_dval;
      mon_sop  = bus2.mactx_txfifo_sop;
      mon_eop  = bus2.mactx_txfifo_eop;
      mon_data = bus2.mactx_txfifo_data;
      mon_rdy  = bus2.slink_mm_rdy;
      mon_err  = err2;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_dval) begin
      q_data.push_back(mon_data);
      q_sop.push_back(mon_sop);
      q_eop.push_back(mon_eop);
      q_cyc.push_back(cyc);
    end
    if (mon_err) err_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    q_data.delete();
    q_sop.delete();
    q_eop.delete();
    q_cyc.delete();
    err_cnt = 0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [17:0] w, input logic odd, output bit ok);
    drv_data = w;
    drv_odd  = odd;
    drv_dval = 1'b1;
    ok       = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (mon_rdy) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    drv_dval = 1'b0;
  endtask

  task automatic wait_rdy(output int c, output bit ok);
    ok = 1'b0;
    c  = -1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (mon_rdy) begin
        ok = 1'b1;
        c  = cyc;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (mon_rdy !== 1'b0) begin
      failures++;
      $display("FAIL reset_rdy got=%b exp=0", mon_rdy);
    end
    checks++;
    if ({mon_dval, mon_sop, mon_eop, mon_data, mon_err} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=000", {mon_dval, mon_sop, mon_eop, mon_data, mon_err});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (mon_rdy !== 1'b0) begin
      failures++;
      $display("FAIL reset_rdy_release got=%b exp=0", mon_rdy);
    end
    @(negedge clk);
    checks++;
    if (mon_rdy !== 1'b1) begin
      failures++;
      $display("FAIL reset_rdy_rise got=%b exp=1", mon_rdy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    logic [7:0] exp_b [6];
    bit ok1, ok2, ok3, okr;
    int c;
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    clear_log();
    send_word({2'b10, 16'h1122}, 1'b0, ok1);
    send_word({2'b00, 16'h3344}, 1'b0, ok2);
    send_word({2'b01, 16'h5566}, 1'b0, ok3);
    wait_rdy(c, okr);
    checks++;
    if (!(ok1 && ok2 && ok3 && okr)) begin
      failures++;
      $display("FAIL basic_handshake got=%b%b%b%b exp=1111", ok1, ok2, ok3, okr);
    end
    checks++;
    if (q_data.size() != 6) begin
      failures++;
      $display("FAIL basic_count got=%0d exp=6", q_data.size());
    end
    for (int i = 0; i < 6; i++) begin
      logic [9:0] got, exp;
      got = (i < q_data.size()) ? {q_sop[i], q_eop[i], q_data[i]} : 10'bx;
      exp = {(i == 0), (i == 5), exp_b[i]};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL basic_byte%0d got=%h exp=%h", i, got, exp);
      end
    end
    checks++;
    if (q_cyc.size() != 6 || q_cyc[5] - q_cyc[0] != 5) begin
      failures++;
      $display("FAIL basic_consecutive got_bytes=%0d exp_span=5", q_cyc.size());
    end
    checks++;
    if (q_cyc.size() != 6 || c - q_cyc[5] - 1 != 12) begin
      failures++;
      $display("FAIL basic_ifg got=%0d exp=12", (q_cyc.size() == 6) ? c - q_cyc[5] - 1 : -1);
    end
  endtask

  task automatic test_odd();
    logic [7:0] exp_b [3];
    bit ok1, ok2, okr;
    int c;
    exp_b = '{8'hA1, 8'hB2, 8'hC3};
    clear_log();
    send_word({2'b10, 16'hA1B2}, 1'b0, ok1);
    send_word({2'b01, 16'hC35A}, 1'b1, ok2);
    wait_rdy(c, okr);
    checks++;
    if (!(ok1 && ok2 && okr)) begin
      failures++;
      $display("FAIL odd_handshake got=%b%b%b exp=111", ok1, ok2, okr);
    end
    checks++;
    if (q_data.size() != 3) begin
      failures++;
      $display("FAIL odd_count got=%0d exp=3", q_data.size());
    end
    for (int i = 0; i < 3; i++) begin
      logic [9:0] got, exp;
      got = (i < q_data.size()) ? {q_sop[i], q_eop[i], q_data[i]} : 10'bx;
      exp = {(i == 0), (i == 2), exp_b[i]};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL odd_byte%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_nosop();
    bit ok1;
    clear_log();
    send_word({2'b00, 16'hDEAD}, 1'b0, ok1);
    idle_cycles(4);
    @(negedge clk);
    checks++;
    if (!ok1 || mon_rdy !== 1'b1) begin
      failures++;
      $display("FAIL nosop_rdy got=%b exp=1", mon_rdy);
    end
    checks++;
    if (err_cnt != 1) begin
      failures++;
      $display("FAIL nosop_err got=%0d exp=1", err_cnt);
    end
    checks++;
    if (q_data.size() != 0) begin
      failures++;
      $display("FAIL nosop_bytes got=%0d exp=0", q_data.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_afull();
    logic [7:0] exp_b [8];
    bit ok1, ok2, ok3, ok4, okr;
    int c, steps;
    exp_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    clear_log();
    fork
      begin
        send_word({2'b10, 16'h0102}, 1'b0, ok1);
        send_word({2'b00, 16'h0304}, 1'b0, ok2);
        send_word({2'b00, 16'h0506}, 1'b0, ok3);
        send_word({2'b01, 16'h0708}, 1'b0, ok4);
      end
      begin
        repeat (3) @(posedge clk);
        #1 drv_afull = 1'b1;
        repeat (3) @(posedge clk);
        #1 drv_afull = 1'b0;
      end
    join
    wait_rdy(c, okr);
    checks++;
    if (!(ok1 && ok2 && ok3 && ok4 && okr)) begin
      failures++;
      $display("FAIL afull_handshake got=%b%b%b%b%b exp=11111", ok1, ok2, ok3, ok4, okr);
    end
    checks++;
    if (q_data.size() != 8) begin
      failures++;
      $display("FAIL afull_count got=%0d exp=8", q_data.size());
    end
    for (int i = 0; i < 8; i++) begin
      logic [9:0] got, exp;
      got = (i < q_data.size()) ? {q_sop[i], q_eop[i], q_data[i]} : 10'bx;
      exp = {(i == 0), (i == 7), exp_b[i]};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL afull_byte%0d got=%h exp=%h", i, got, exp);
      end
    end
    steps = 0;
    for (int i = 1; i < q_cyc.size(); i++) if (q_cyc[i] - q_cyc[i-1] != 1) steps++;
    checks++;
    if (q_cyc.size() != 8 || q_cyc[7] - q_cyc[0] != 10 || steps != 1) begin
      failures++;
      $display("FAIL afull_pause got_span=%0d got_breaks=%0d exp_span=10 exp_breaks=1",
               (q_cyc.size() == 8) ? q_cyc[7] - q_cyc[0] : -1, steps);
    end
  endtask

  task automatic test_wait_sop();
    logic [7:0] exp_b [4];
    bit ok1, ok2, okr;
    int c;
    exp_b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    clear_log();
    send_word({2'b10, 16'hAABB}, 1'b0, ok1);
    idle_cycles(4);
    send_word({2'b11, 16'hCCDD}, 1'b0, ok2);
    wait_rdy(c, okr);
    checks++;
    if (!(ok1 && ok2 && okr)) begin
      failures++;
      $display("FAIL wait_handshake got=%b%b%b exp=111", ok1, ok2, okr);
    end
    checks++;
    if (err_cnt != 1) begin
      failures++;
      $display("FAIL wait_err got=%0d exp=1", err_cnt);
    end
    checks++;
    if (q_data.size() != 4) begin
      failures++;
      $display("FAIL wait_count got=%0d exp=4", q_data.size());
    end
    for (int i = 0; i < 4; i++) begin
      logic [9:0] got, exp;
      got = (i < q_data.size()) ? {q_sop[i], q_eop[i], q_data[i]} : 10'bx;
      exp = {(i == 0), (i == 3), exp_b[i]};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL wait_byte%0d got=%h exp=%h", i, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_f [3];
    bit ok1, ok2, okr;
    int c;
    exp_f = '{{2'b10, 8'h77}, {2'b01, 8'h88}, {2'b11, 8'h99}};
    clear_log();
    send_word({2'b11, 16'h7788}, 1'b0, ok1);
    send_word({2'b11, 16'h99AA}, 1'b1, ok2);
    wait_rdy(c, okr);
    checks++;
    if (!(ok1 && ok2 && okr) || q_data.size() != 3) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=3", q_data.size());
    end
    for (int i = 0; i < 3; i++) begin
      logic [9:0] got;
      got = (i < q_data.size()) ? {q_sop[i], q_eop[i], q_data[i]} : 10'bx;
      checks++;
      if (got !== exp_f[i]) begin
        failures++;
        $display("FAIL b2b_byte%0d got=%h exp=%h", i, got, exp_f[i]);
      end
    end
    checks++;
    if (q_cyc.size() != 3 || q_cyc[2] - q_cyc[1] != 15) begin
      failures++;
      $display("FAIL b2b_spacing got=%0d exp=15", (q_cyc.size() == 3) ? q_cyc[2] - q_cyc[1] : -1);
    end
  endtask

  task automatic test_maxlen();
    logic [7:0] exp_b [6];
    bit ok1, ok2, ok3, ok4, ok5, okr;
    int c;
    exp_b = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    sel = 1;
    clear_log();
    send_word({2'b10, 16'h1011}, 1'b0, ok1);
    send_word({2'b00, 16'h1213}, 1'b0, ok2);
    send_word({2'b00, 16'h1415}, 1'b0, ok3);
    send_word({2'b00, 16'h1617}, 1'b0, ok4);
    send_word({2'b01, 16'h1819}, 1'b0, ok5);
    wait_rdy(c, okr);
    checks++;
    if (!(ok1 && ok2 && ok3 && ok4 && ok5 && okr)) begin
      failures++;
      $display("FAIL maxlen_handshake got=%b%b%b%b%b%b exp=111111", ok1, ok2, ok3, ok4, ok5, okr);
    end
    checks++;
    if (err_cnt != 1) begin
      failures++;
      $display("FAIL maxlen_err got=%0d exp=1", err_cnt);
    end
    checks++;
    if (q_data.size() != 6) begin
      failures++;
      $display("FAIL maxlen_count got=%0d exp=6", q_data.size());
    end
    for (int i = 0; i < 6; i++) begin
      logic [9:0] got, exp;
      got = (i < q_data.size()) ? {q_sop[i], q_eop[i], q_data[i]} : 10'bx;
      exp = {(i == 0), (i == 5), exp_b[i]};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL maxlen_byte%0d got=%h exp=%h", i, got, exp);
      end
    end
    sel = 0;
  endtask

  task automatic test_reset_midframe();
    bit ok1;
    int eops;
    clear_log();
    send_word({2'b10, 16'h1234}, 1'b0, ok1);
    rst = 1'b1;
    idle_cycles(2);
    rst = 1'b0;
    idle_cycles(3);
    eops = 0;
    foreach (q_eop[i]) if (q_eop[i]) eops++;
    checks++;
    if (!ok1 || eops != 0 || mon_dval !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_eop got=%0d exp=0", eops);
    end
    @(negedge clk);
    checks++;
    if (mon_rdy !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_rdy got=%b exp=1", mon_rdy);
    end
    @(posedge clk);
    #1;
  endtask

`ifdef BACDCTX_PAD_EN
  task automatic test_pad();
    logic [7:0] exp_b [8];
    bit ok1, okr;
    int c;
    exp_b = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    sel = 2;
    clear_log();
    send_word({2'b11, 16'h0102}, 1'b0, ok1);
    wait_rdy(c, okr);
    checks++;
    if (!(ok1 && okr) || q_data.size() != 8) begin
      failures++;
      $display("FAIL pad_count got=%0d exp=8", q_data.size());
    end
    for (int i = 0; i < 8; i++) begin
      logic [9:0] got, exp;
      got = (i < q_data.size()) ? {q_sop[i], q_eop[i], q_data[i]} : 10'bx;
      exp = {(i == 0), (i == 7), exp_b[i]};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL pad_byte%0d got=%h exp=%h", i, got, exp);
      end
    end
    sel = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_odd();
    test_nosop();
    test_afull();
    test_wait_sop();
    test_back_to_back();
    test_maxlen();
    test_reset_midframe();
`ifdef BACDCTX_PAD_EN
    test_pad();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
